// File: rtl/ddr_pkg.sv
// Shared types and timing windows for the arrow judgement path.
package ddr_pkg;

   typedef enum logic [2:0] {
      MARV  = 3'd0,
      PERF  = 3'd1,
      GREAT = 3'd2,
      GOOD  = 3'd3,
      BOO   = 3'd4,
      MISS  = 3'd5
   } grade_t;

   typedef enum logic [1:0] {
      LANE_IDLE      = 2'd0,
      LANE_ARMED     = 2'd1,
      LANE_JUDGED    = 2'd2,
      LANE_MISS_PEND = 2'd3
   } lane_state_t;

   // Windows nest around y=53; each grade owns the band outside the tighter one.
   localparam int MARV_LO  = 46;
   localparam int MARV_HI  = 60;
   localparam int PERF_LO  = 36;
   localparam int PERF_HI  = 70;
   localparam int GREAT_LO = 16;
   localparam int GREAT_HI = 90;
   localparam int GOOD_LO  = 1;
   localparam int GOOD_HI  = 105;

   function automatic logic [2:0] grade_points(input grade_t g);
      case (g)
         MARV:    return 3'd4;
         PERF:    return 3'd3;
         GREAT:   return 3'd2;
         GOOD:    return 3'd1;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/arrow_judge_if.sv
// Column-side bundle between the arrow movement stage, the judge and the HUD.
interface arrow_judge_if #(
   parameter int CORDW       = 10,
   parameter int ARROW_COUNT = 3,
   parameter int SCOREW      = 16,
   parameter int COMBOW      = 10
);
   import ddr_pkg::*;

   localparam int LANEW = $clog2(ARROW_COUNT);

   logic                           clear_i;
   logic [CORDW*ARROW_COUNT-1:0]   arrow_y_i;
   logic                           btn_i;
   logic                           judge_valid_o;
   grade_t                         judge_o;
   logic [LANEW-1:0]               lane_o;
   logic [SCOREW-1:0]              score_o;
   logic [COMBOW-1:0]              combo_o;
   logic [COMBOW-1:0]              max_combo_o;

   modport master (
      output clear_i, arrow_y_i, btn_i,
      input  judge_valid_o, judge_o, lane_o, score_o, combo_o, max_combo_o
   );

   modport slave (
      input  clear_i, arrow_y_i, btn_i,
      output judge_valid_o, judge_o, lane_o, score_o, combo_o, max_combo_o
   );

endinterface

// File: rtl/grade_lookup.sv
// Combinational y -> grade mapping; also used by the HUD colour logic.
module grade_lookup
   import ddr_pkg::*;
#(
   parameter int CORDW       = 10,
   parameter int JUDGE_MAX_Y = 125
) (
   input  logic [CORDW-1:0] y,
   output grade_t           grade
);

   int y_int;

   always_comb begin
      y_int = int'(y);
      grade = MISS;
      if (y_int >= MARV_LO && y_int <= MARV_HI)
         grade = MARV;
      else if (y_int >= PERF_LO && y_int <= PERF_HI)
         grade = PERF;
      else if (y_int >= GREAT_LO && y_int <= GREAT_HI)
         grade = GREAT;
      else if (y_int >= GOOD_LO && y_int <= GOOD_HI)
         grade = GOOD;
      else if (y_int > GOOD_HI && y_int <= JUDGE_MAX_Y)
         grade = BOO;
   end

endmodule

// File: rtl/arrow_judge.sv
// Grades column presses against the target window, detects missed arrows and
// keeps score / combo / max-combo for the HUD.
module arrow_judge
   import ddr_pkg::*;
#(
   parameter int CORDW        = 10,
   parameter int ARROW_COUNT  = 3,
   parameter int ARROWY_BEGIN = 480,
   parameter int JUDGE_MAX_Y  = 125,
   parameter int SCOREW       = 16,
   parameter int COMBOW       = 10
) (
   input logic          clk_i,
   input logic          reset_ni,
   arrow_judge_if.slave bus
);

   localparam int LANEW = $clog2(ARROW_COUNT);
   localparam logic [CORDW-1:0] Y_HOME = CORDW'(ARROWY_BEGIN);
   localparam logic [CORDW-1:0] Y_MAX  = CORDW'(JUDGE_MAX_Y);

   function automatic logic [SCOREW-1:0] sat_add_score(input logic [SCOREW-1:0] acc,
                                                       input logic [2:0]        pts);
      logic [SCOREW:0] sum;
      sum = {1'b0, acc} + (SCOREW+1)'(pts);
      return sum[SCOREW] ? '1 : sum[SCOREW-1:0];
   endfunction

   function automatic logic [COMBOW-1:0] sat_inc_combo(input logic [COMBOW-1:0] c);
      return (&c) ? c : c + COMBOW'(1);
   endfunction

   logic [CORDW-1:0]  y_p0 [ARROW_COUNT];
   logic [CORDW-1:0]  y_p1 [ARROW_COUNT];
   lane_state_t       state_q [ARROW_COUNT];
   lane_state_t       state_d [ARROW_COUNT];

   logic              btn_q;
   logic              press;
   logic              elig_any;
   logic              hit;
   logic              miss_any;
   logic              drain;
   logic [LANEW-1:0]  sel_lane;
   logic [LANEW-1:0]  miss_lane;
   logic [CORDW-1:0]  sel_y;
   grade_t            sel_grade;

   logic              ev_valid;
   grade_t            ev_grade;
   logic [LANEW-1:0]  ev_lane;
   logic [SCOREW-1:0] score_d;
   logic [COMBOW-1:0] combo_d;
   logic [COMBOW-1:0] max_combo_d;

   logic              vld_p1;
   grade_t            grade_p1;
   logic [LANEW-1:0]  lane_p1;
   logic [SCOREW-1:0] score_p1;
   logic [COMBOW-1:0] combo_p1;
   logic [COMBOW-1:0] max_combo_p1;

   // ---- stage p0: unpack lanes (arrow 0 in the MS slice), detect press ----
   always_comb begin
      for (int i = 0; i < ARROW_COUNT; i++)
         y_p0[i] = bus.arrow_y_i[CORDW*(ARROW_COUNT-i)-1 -: CORDW];
   end

   assign press = bus.btn_i & ~btn_q;

   // Judging uses last cycle's y so a press on the cycle an arrow snaps home still lands.
   always_comb begin
      elig_any = 1'b0;
      sel_lane = '0;
      sel_y    = '0;
      for (int i = 0; i < ARROW_COUNT; i++) begin
         if (state_q[i] == LANE_ARMED && y_p1[i] != '0 && y_p1[i] <= Y_MAX) begin
            if (!elig_any || y_p1[i] < sel_y) begin
               elig_any = 1'b1;
               sel_lane = LANEW'(i);
               sel_y    = y_p1[i];
            end
         end
      end
   end

   always_comb begin
      miss_any  = 1'b0;
      miss_lane = '0;
      for (int i = ARROW_COUNT - 1; i >= 0; i--) begin
         if (state_q[i] == LANE_MISS_PEND) begin
            miss_any  = 1'b1;
            miss_lane = LANEW'(i);
         end
      end
   end

   assign hit   = press & elig_any;
   assign drain = miss_any & ~hit;

   grade_lookup #(
      .CORDW       (CORDW),
      .JUDGE_MAX_Y (JUDGE_MAX_Y)
   ) u_grade_lookup (
      .y     (sel_y),
      .grade (sel_grade)
   );

   always_comb begin
      for (int i = 0; i < ARROW_COUNT; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            LANE_IDLE:
               if (y_p0[i] != Y_HOME) state_d[i] = LANE_ARMED;
            LANE_ARMED:
               if (hit && sel_lane == LANEW'(i)) state_d[i] = LANE_JUDGED;
               else if (y_p0[i] == Y_HOME)       state_d[i] = LANE_MISS_PEND;
            LANE_JUDGED:
               if (y_p0[i] == Y_HOME) state_d[i] = LANE_IDLE;
            LANE_MISS_PEND:
               if (drain && miss_lane == LANEW'(i)) state_d[i] = LANE_IDLE;
            default:
               state_d[i] = LANE_IDLE;
         endcase
      end
   end

   always_comb begin
      ev_valid    = hit | drain;
      ev_grade    = hit ? sel_grade : MISS;
      ev_lane     = hit ? sel_lane : miss_lane;
      score_d     = sat_add_score(score_p1, grade_points(ev_grade));
      combo_d     = (ev_grade == BOO || ev_grade == MISS) ? '0 : sat_inc_combo(combo_p1);
      max_combo_d = (combo_d > max_combo_p1) ? combo_d : max_combo_p1;
   end

   // ---- stage p1: registered event, counters and lane state ----
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < ARROW_COUNT; i++)
         y_p1[i] <= y_p0[i];
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         btn_q        <= 1'b0;
         vld_p1       <= 1'b0;
         grade_p1     <= MARV;
         lane_p1      <= '0;
         score_p1     <= '0;
         combo_p1     <= '0;
         max_combo_p1 <= '0;
         for (int i = 0; i < ARROW_COUNT; i++)
            state_q[i] <= LANE_IDLE;
      end else if (bus.clear_i) begin
         btn_q        <= 1'b0;
         vld_p1       <= 1'b0;
         grade_p1     <= MARV;
         lane_p1      <= '0;
         score_p1     <= '0;
         combo_p1     <= '0;
         max_combo_p1 <= '0;
         for (int i = 0; i < ARROW_COUNT; i++)
            state_q[i] <= LANE_IDLE;
      end else begin
         btn_q  <= bus.btn_i;
         vld_p1 <= ev_valid;
         for (int i = 0; i < ARROW_COUNT; i++)
            state_q[i] <= state_d[i];
         if (ev_valid) begin
            grade_p1     <= ev_grade;
            lane_p1      <= ev_lane;
            score_p1     <= score_d;
            combo_p1     <= combo_d;
            max_combo_p1 <= max_combo_d;
         end
      end
   end

   assign bus.judge_valid_o = vld_p1;
   assign bus.judge_o       = grade_p1;
   assign bus.lane_o        = lane_p1;
   assign bus.score_o       = score_p1;
   assign bus.combo_o       = combo_p1;
   assign bus.max_combo_o   = max_combo_p1;

endmodule

// File: tb/tb_arrow_judge.sv
// Bench for arrow_judge: directed scenarios plus random arrow traffic against a flag-based model.
module tb_arrow_judge;
   import ddr_pkg::*;

   localparam int HOME = 480;

   logic clk_i    = 1'b0;
   logic reset_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   arrow_judge_if #(.CORDW(10), .ARROW_COUNT(3), .SCOREW(16), .COMBOW(10)) bus  ();
   arrow_judge_if #(.CORDW(10), .ARROW_COUNT(3), .SCOREW(4),  .COMBOW(10)) bus4 ();

   assign bus4.clear_i   = bus.clear_i;
   assign bus4.arrow_y_i = bus.arrow_y_i;
   assign bus4.btn_i     = bus.btn_i;

   arrow_judge #(.CORDW(10), .ARROW_COUNT(3), .ARROWY_BEGIN(480), .JUDGE_MAX_Y(125),
                 .SCOREW(16), .COMBOW(10)) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   arrow_judge #(.CORDW(10), .ARROW_COUNT(3), .ARROWY_BEGIN(480), .JUDGE_MAX_Y(125),
                 .SCOREW(4), .COMBOW(10)) dut4 (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .bus      (bus4)
   );

   int checks   = 0;
   int failures = 0;

   // stimulus
   int y [3];
   bit btn;
   bit clr;

   // model
   bit live [3];
   bit owed [3];
   bit done [3];
   int yreg [3];
   bit bprev;
   bit m_valid;
   int m_lane, m_grade;
   int m_score, m_score4, m_combo, m_max;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Windows are symmetric bands around y=53: +-7 MARV, +-17 PERF, +-37 GREAT, +-52 GOOD.
   function automatic int grade_of(input int yy);
      int d;
      d = (yy > 53) ? yy - 53 : 53 - yy;
      if (d <= 7)  return 0;
      if (d <= 17) return 1;
      if (d <= 37) return 2;
      if (d <= 52) return 3;
      return 4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         live[i] = 0; owed[i] = 0; done[i] = 0; yreg[i] = y[i];
      end
      bprev = 0; m_valid = 0; m_score = 0; m_score4 = 0; m_combo = 0; m_max = 0;
      m_lane = 0; m_grade = 0;
   endtask

   task automatic model_step();
      int best, drained, pts;
      bit pr;
      m_valid = 0;
      if (clr) begin
         model_reset();
      end else begin
         pr   = btn && !bprev;
         best = -1;
         for (int i = 0; i < 3; i++)
            if (live[i] && yreg[i] >= 1 && yreg[i] <= 125 && (best < 0 || yreg[i] < yreg[best]))
               best = i;
         drained = -1;
         if (pr && best >= 0) begin
            m_valid = 1; m_lane = best; m_grade = grade_of(yreg[best]);
         end else begin
            for (int i = 2; i >= 0; i--)
               if (owed[i]) drained = i;
            if (drained >= 0) begin
               m_valid = 1; m_lane = drained; m_grade = 5;
            end
         end
         if (!(pr && best >= 0)) best = -1;
         for (int i = 0; i < 3; i++) begin
            if (owed[i]) begin
               if (drained == i) owed[i] = 0;
            end else if (live[i]) begin
               if (best == i)            begin live[i] = 0; done[i] = 1; end
               else if (y[i] == HOME)    begin live[i] = 0; owed[i] = 1; end
            end else if (done[i]) begin
               if (y[i] == HOME) done[i] = 0;
            end else if (y[i] != HOME) begin
               live[i] = 1;
            end
         end
         if (m_valid) begin
            pts      = (m_grade < 4) ? 4 - m_grade : 0;
            m_score  = (m_score + pts > 65535) ? 65535 : m_score + pts;
            m_score4 = (m_score4 + pts > 15) ? 15 : m_score4 + pts;
            m_combo  = (m_grade < 4) ? ((m_combo == 1023) ? 1023 : m_combo + 1) : 0;
            if (m_combo > m_max) m_max = m_combo;
         end
         bprev = btn;
         for (int i = 0; i < 3; i++) yreg[i] = y[i];
      end
   endtask

   task automatic drive();
      logic [9:0] a, b, c;
      a = 10'(y[0]); b = 10'(y[1]); c = 10'(y[2]);
      bus.arrow_y_i = {a, b, c};
      bus.btn_i     = btn;
      bus.clear_i   = clr;
   endtask

   task automatic tick();
      drive();
      model_step();
      @(posedge clk_i);
      #1;
      check("valid", int'(bus.judge_valid_o), int'(m_valid));
      if (m_valid) begin
         check("grade", int'(bus.judge_o), m_grade);
         check("lane", int'(bus.lane_o), m_lane);
      end
      check("score", int'(bus.score_o), m_score);
      check("combo", int'(bus.combo_o), m_combo);
      check("max_combo", int'(bus.max_combo_o), m_max);
      check("score_sat4", int'(bus4.score_o), m_score4);
   endtask

   task automatic home_all();
      for (int i = 0; i < 3; i++) y[i] = HOME;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, int'(bus.judge_valid_o), 0);
      check({tag, "_grade"}, int'(bus.judge_o), 0);
      check({tag, "_lane"}, int'(bus.lane_o), 0);
      check({tag, "_score"}, int'(bus.score_o), 0);
      check({tag, "_combo"}, int'(bus.combo_o), 0);
      check({tag, "_max"}, int'(bus.max_combo_o), 0);
      check({tag, "_score4"}, int'(bus4.score_o), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      home_all(); btn = 0; clr = 0;
      drive();
      reset_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check_zero("reset");
      @(negedge clk_i);
      reset_ni = 1'b1;
      model_reset();
      tick();

      // 1: single MARV, then held button gives nothing more
      y[0] = 50; tick();
      btn = 1; tick();
      check("t1_grade", int'(bus.judge_o), int'(MARV));
      check("t1_score", int'(bus.score_o), 4);
      repeat (20) tick();
      btn = 0; y[0] = HOME; tick();

      // 2: nearest eligible lane first, the other stays armed
      y[1] = 40; y[2] = 100; tick();
      btn = 1; tick();
      check("t2_lane_a", int'(bus.lane_o), 1);
      btn = 0; tick();
      btn = 1; tick();
      check("t2_grade_b", int'(bus.judge_o), int'(GOOD));
      btn = 0; y[1] = HOME; y[2] = HOME; tick();

      // 3: unhit arrow goes home -> miss; combo drops, max kept
      y[0] = 5; tick();
      y[0] = HOME; tick();
      tick();
      check("t3_grade", int'(bus.judge_o), int'(MISS));
      check("t3_max", int'(bus.max_combo_o), 3);
      tick();

      // 4: BOO, then presses with nothing eligible
      y[0] = 110; tick();
      btn = 1; tick();
      check("t4_boo", int'(bus.judge_o), int'(BOO));
      btn = 0; y[0] = HOME; tick();
      btn = 1; tick();
      btn = 0; y[1] = 200; tick();
      btn = 1; tick();
      btn = 0; y[1] = HOME; repeat (3) tick();

      // 5: hit wins over a simultaneous miss; the miss follows
      y[0] = 130; y[1] = 55; tick();
      y[0] = HOME; btn = 1; tick();
      check("t5_hit_lane", int'(bus.lane_o), 1);
      btn = 0; tick();
      check("t5_miss_lane", int'(bus.lane_o), 0);
      y[1] = HOME; tick();

      // tie on y goes to the lower index; press on the homing cycle still hits
      y[1] = 80; y[2] = 80; tick();
      btn = 1; tick();
      check("tie_lane", int'(bus.lane_o), 1);
      btn = 0; tick();
      y[2] = HOME; btn = 1; tick();
      check("home_hit_lane", int'(bus.lane_o), 2);
      btn = 0; y[1] = HOME; repeat (2) tick();

      // 6: MARV run saturates the narrow score
      for (int k = 0; k < 4; k++) begin
         y[0] = 53; tick();
         btn = 1; tick();
         btn = 0; y[0] = HOME; tick();
      end
      check("sat4_top", int'(bus4.score_o), 15);

      // reset mid-judgement clears outputs without waiting for a clock
      y[0] = 50; tick();
      btn = 1; drive();
      @(posedge clk_i); #2;
      reset_ni = 1'b0;
      #1;
      check_zero("async_rst");
      btn = 0; home_all(); drive();
      @(posedge clk_i); #1;
      reset_ni = 1'b1;
      model_reset();
      tick();

      // random traffic
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (y[i] == HOME) begin
               if ($urandom_range(7) == 0) y[i] = 126 + $urandom_range(60);
            end else begin
               y[i] = y[i] - $urandom_range(4);
               if (y[i] < 1) y[i] = HOME;
            end
         end
         if ($urandom_range(3) == 0) btn = ~btn;
         tick();
      end

      // synchronous clear
      clr = 1; tick();
      check("clr_score", int'(bus.score_o), 0);
      check("clr_max", int'(bus.max_combo_o), 0);
      clr = 0; btn = 0; home_all(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arrow_judge.md
Name: arrow_judge

Overview:
Downstream of the arrow movement stage for one lane column. Consumes the packed per-arrow y positions and the column's button, and grades each press against the target window. Detects arrows that leave without being hit. Emits a one-cycle judgement event plus running score, combo and max-combo for the HUD/score display.

Parameters:
CORDW, 10, y-coordinate width per arrow
ARROW_COUNT, 3, arrows packed in arrow_y_i
ARROWY_BEGIN, 480, idle/home y value of an unlaunched arrow
JUDGE_MAX_Y, 125, largest y at which a press can be judged
SCOREW, 16, score width (saturating)
COMBOW, 10, combo / max-combo width (saturating)

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear of score/combo/max-combo and lane state (song start)
arrow_y_i  in  CORDW*ARROW_COUNT  packed y positions; arrow 0 in the MS slice
btn_i  in  1  column button, already debounced and synchronous to clk_i
judge_valid_o  out  1  one-cycle pulse: a judgement was made
judge_o  out  3  grade_t code, valid with judge_valid_o
lane_o  out  $clog2(ARROW_COUNT)  arrow index judged
score_o  out  SCOREW  accumulated points
combo_o  out  COMBOW  current combo
max_combo_o  out  COMBOW  highest combo since clear

Behaviour:
- Reset (async, reset_ni=0): all outputs 0, btn_q=0, every lane IDLE, no pending miss. clear_i has the same effect synchronously; reset_ni has priority over clear_i.
- Press edge: press = btn_i & ~btn_q. btn_q is registered each cycle. A held button yields exactly one press.
- Per-lane FSM:
  - IDLE -> ARMED when y != ARROWY_BEGIN.
  - ARMED -> JUDGED on a hit.
  - ARMED -> MISS_PEND when y returns to ARROWY_BEGIN unhit.
  - JUDGED -> IDLE when y == ARROWY_BEGIN.
  - MISS_PEND -> IDLE once the miss is emitted.
- Eligible lane: ARMED and 1 <= y <= JUDGE_MAX_Y. On press, select the eligible lane with the smallest y. Ties go to the lowest index. A press with no eligible lane is ignored: no event, no combo change.
- Grade by y of the selected lane:
  - 46..60 MARV
  - 36..45 or 61..70 PERF
  - 16..35 or 71..90 GREAT
  - 1..15 or 91..105 GOOD
  - 106..JUDGE_MAX_Y BOO
  - MISS only from MISS_PEND.
- Latency: press detected in cycle N (btn_i high at edge N, btn_q low) -> judge_valid_o, judge_o, lane_o registered and visible at N+1. Score and combo update in the same cycle as judge_valid_o.
- Points: MARV 4, PERF 3, GREAT 2, GOOD 1, BOO 0, MISS 0. score_o adds with saturation at all-ones.
- Combo:
  - MARV/PERF/GREAT/GOOD increment combo, saturating.
  - BOO/MISS set combo to 0.
  - max_combo_o <= max(max_combo_o, new combo), updated in the same cycle.
- Arbitration: at most one event per cycle. A hit has priority over a pending miss. Pending misses drain one per cycle, lowest index first, on cycles with no hit. A lane in MISS_PEND is not eligible and cannot re-arm until drained.
- Arrow re-launched (leaves ARROWY_BEGIN) while still MISS_PEND: the lane stays MISS_PEND. After draining it goes IDLE, then re-arms on the next cycle because y != ARROWY_BEGIN.
- A press in the same cycle an eligible arrow reaches ARROWY_BEGIN uses the registered y (<= JUDGE_MAX_Y) and counts as a hit, not a miss.

Decomposition:
- ddr_pkg:
  - grade_t enum (MARV=0, PERF, GREAT, GOOD, BOO, MISS)
  - window boundary localparams
  - points-per-grade function
  - lane_state_t enum
- Sub-module grade_lookup: combinational y -> grade_t. It is reused by the HUD colour logic.
- Lane FSMs, arbiter and score/combo counters stay in arrow_judge.

Test Plan:
1. Lane 0 at y=50, press -> next cycle: judge_valid_o=1, judge_o=MARV, lane_o=0, score 0->4, combo 1, max_combo 1. Holding btn_i high 20 cycles produces no further event.
2. Lanes 1 and 2 at y=40 and y=100, one press -> PERF on lane 1, score +3. Lane 2 stays ARMED. A second press -> GOOD on lane 2.
3. Build combo 3, then lane 0 falls 5->ARROWY_BEGIN unpressed -> MISS on lane 0 one cycle later, combo 0, max_combo stays 3, score unchanged.
4. Press at y=110 -> BOO, score +0, combo 0. Press with all lanes at 480 or y=200 -> no event.
5. Same cycle: lane 0 enters MISS_PEND and a press hits lane 1 at y=55 -> MARV on lane 1 first, MISS on lane 0 the following cycle.
6. SCOREW=4: repeated MARV saturates score at 15. reset_ni low mid-judgement -> all outputs 0 immediately. clear_i -> zeros on next edge.
